// File: rtl/demux_1x3_frame_reg.sv
// demux_1x3_frame_reg: steers a W-bit handshaked stream into three held channel registers released as one frame (optional sticky overwrite error via DEMUX_OVW_ERR_EN)
module demux_1x3_frame_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         seq_mode,
  input  logic [1:0]   select,
  input  logic [W-1:0] data_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         frame_ack,
  output logic [W-1:0] ch_0,
  output logic [W-1:0] ch_1,
  output logic [W-1:0] ch_2,
  output logic [2:0]   ch_valid,
  output logic         frame_valid
`ifdef DEMUX_OVW_ERR_EN
  ,
  output logic         err_ovw
`endif
);
  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;
  state_t state, state_nx;
  logic       mode, mode_nx, acc, clr, eff;
  logic [1:0] ptr, ptr_nx, pb, tgt;
  logic [2:0] vb, oh, v_nx;
  // next-state: an ack in FULL clears valids/ptr first, then any same-cycle write lands on the cleared frame
  always_comb begin
    in_ready    = (state != FULL) | frame_ack;
    acc         = in_valid & in_ready;
    clr         = frame_ack & (state == FULL);
    eff         = (state == IDLE || clr) ? seq_mode : mode;
    mode_nx     = (acc && (state == IDLE || clr)) ? seq_mode : mode;
    vb          = clr ? 3'b000 : ch_valid;
    pb          = clr ? 2'd0 : ptr;
    tgt         = eff ? pb : select;
    oh          = (acc && tgt != 2'd3) ? 3'b001 << tgt : 3'b000;
    v_nx        = vb | oh;
    ptr_nx      = (acc && eff) ? (pb == 2'd2 ? 2'd0 : pb + 2'd1) : pb;
    state_nx    = (v_nx == 3'b111) ? FULL : (v_nx == 3'b000) ? IDLE : FILL;
    frame_valid = state == FULL;
  end
  // state, pointer, mode latch and channel registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      mode     <= 1'b0;
      ptr      <= 2'd0;
      ch_valid <= 3'b000;
      ch_0     <= '0;
      ch_1     <= '0;
      ch_2     <= '0;
    end else begin
      state    <= state_nx;
      mode     <= mode_nx;
      ptr      <= ptr_nx;
      ch_valid <= v_nx;
      if (oh[0]) ch_0 <= data_in;
      if (oh[1]) ch_1 <= data_in;
      if (oh[2]) ch_2 <= data_in;
    end
  end
`ifdef DEMUX_OVW_ERR_EN
  // sticky flag: a direct-mode write hit a channel that was still valid
  always_ff @(posedge clk) begin
    if (!rst) err_ovw <= 1'b0;
    else if (!eff && (oh & vb) != 3'b000) err_ovw <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_demux_1x3_frame_reg.sv
// tb_demux_1x3_frame_reg: directed scoreboard bench for demux_1x3_frame_reg
module tb_demux_1x3_frame_reg;
  logic        clk, rst, seq_mode, in_valid, in_ready, frame_ack, frame_valid;
  logic [1:0]  select;
  logic [31:0] data_in, ch_0, ch_1, ch_2;
  logic [2:0]  ch_valid;
`ifdef DEMUX_OVW_ERR_EN
  logic        err_ovw;
`endif
  typedef struct packed {
    logic [31:0] c0, c1, c2;
    logic [2:0]  v;
    logic        err;
  } exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;

  demux_1x3_frame_reg #(.W(32)) dut (
    .clk(clk), .rst(rst), .seq_mode(seq_mode), .select(select), .data_in(data_in),
    .in_valid(in_valid), .in_ready(in_ready), .frame_ack(frame_ack),
    .ch_0(ch_0), .ch_1(ch_1), .ch_2(ch_2), .ch_valid(ch_valid), .frame_valid(frame_valid)
`ifdef DEMUX_OVW_ERR_EN
    , .err_ovw(err_ovw)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, a, x);
    end
  endtask

  // drive one cycle of inputs, queue the state expected after the edge, then idle the inputs
  task automatic step(input logic r, input logic s, input logic [1:0] sl, input logic [31:0] d,
                      input logic iv, input logic ack, input logic [31:0] e0, input logic [31:0] e1,
                      input logic [31:0] e2, input logic [2:0] ev, input logic ee);
    exp_t e;
    rst = r; seq_mode = s; select = sl; data_in = d; in_valid = iv; frame_ack = ack;
    @(posedge clk);
    e.c0 = e0; e.c1 = e1; e.c2 = e2; e.v = ev; e.err = ee;
    q.push_back(e);
    #1;
    rst = 1'b1; in_valid = 1'b0; frame_ack = 1'b0; data_in = 32'hDEAD_BEEF;
    @(negedge clk);
    #1;
  endtask

  // monitor: compare every presented output against the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("ch_0", ch_0, e.c0);
      chk("ch_1", ch_1, e.c1);
      chk("ch_2", ch_2, e.c2);
      chk("ch_valid", 32'(ch_valid), 32'(e.v));
      chk("frame_valid", 32'(frame_valid), 32'(e.v == 3'b111));
      chk("in_ready", 32'(in_ready), 32'(e.v != 3'b111));
`ifdef DEMUX_OVW_ERR_EN
      chk("err_ovw", 32'(err_ovw), 32'(e.err));
`endif
    end
  end

  initial begin
    rst = 1'b0; seq_mode = 1'b0; select = 2'd0; data_in = '0; in_valid = 1'b0; frame_ack = 1'b0;
    step(0, 0, 0, 32'h00, 0, 0, 32'h00, 32'h00, 32'h00, 3'b000, 0);
    step(0, 1, 0, 32'h99, 1, 0, 32'h00, 32'h00, 32'h00, 3'b000, 0);
    // T1: sequential fill
    step(1, 1, 0, 32'hA1, 1, 0, 32'hA1, 32'h00, 32'h00, 3'b001, 0);
    step(1, 1, 3, 32'hB2, 1, 0, 32'hA1, 32'hB2, 32'h00, 3'b011, 0);
    step(1, 1, 3, 32'hC3, 1, 0, 32'hA1, 32'hB2, 32'hC3, 3'b111, 0);
    frame_ack = 1'b1; #1;
    chk("in_ready_ack_full", 32'(in_ready), 32'd1);
    frame_ack = 1'b0; #1;
    chk("in_ready_full", 32'(in_ready), 32'd0);
    // backpressure: write in FULL without ack has no effect
    step(1, 1, 0, 32'hEE, 1, 0, 32'hA1, 32'hB2, 32'hC3, 3'b111, 0);
    // T2: ack plus write in the same cycle
    step(1, 1, 0, 32'hD4, 1, 1, 32'hD4, 32'hB2, 32'hC3, 3'b001, 0);
    step(1, 1, 0, 32'hE5, 1, 0, 32'hD4, 32'hE5, 32'hC3, 3'b011, 0);
    step(1, 1, 0, 32'hF6, 1, 0, 32'hD4, 32'hE5, 32'hF6, 3'b111, 0);
    step(1, 1, 0, 32'h00, 0, 1, 32'hD4, 32'hE5, 32'hF6, 3'b000, 0);
    // T3: direct ch_2 then discard
    step(1, 0, 2, 32'h55, 1, 0, 32'hD4, 32'hE5, 32'h55, 3'b100, 0);
    step(1, 0, 3, 32'h77, 1, 0, 32'hD4, 32'hE5, 32'h55, 3'b100, 0);
    // T4: overwrite ch_1
    step(1, 0, 1, 32'h11, 1, 0, 32'hD4, 32'h11, 32'h55, 3'b110, 0);
    step(1, 0, 1, 32'h22, 1, 0, 32'hD4, 32'h22, 32'h55, 3'b110, 1);
    step(1, 0, 0, 32'h33, 1, 0, 32'h33, 32'h22, 32'h55, 3'b111, 1);
    step(1, 0, 0, 32'h00, 0, 1, 32'h33, 32'h22, 32'h55, 3'b000, 1);
    // T5: partial frame, ack outside FULL ignored, then reset
    step(1, 1, 2, 32'h61, 1, 0, 32'h61, 32'h22, 32'h55, 3'b001, 1);
    step(1, 1, 2, 32'h62, 1, 1, 32'h61, 32'h62, 32'h55, 3'b011, 1);
    step(0, 1, 0, 32'h99, 1, 0, 32'h00, 32'h00, 32'h00, 3'b000, 0);
    step(1, 1, 2, 32'h63, 1, 0, 32'h63, 32'h00, 32'h00, 3'b001, 0);
    // T6: mode change during FILL takes effect after ack
    step(1, 0, 0, 32'h64, 1, 0, 32'h63, 32'h64, 32'h00, 3'b011, 0);
    step(1, 0, 0, 32'h65, 1, 0, 32'h63, 32'h64, 32'h65, 3'b111, 0);
    step(1, 0, 0, 32'h00, 0, 1, 32'h63, 32'h64, 32'h65, 3'b000, 0);
    step(1, 0, 2, 32'h66, 1, 0, 32'h63, 32'h64, 32'h66, 3'b100, 0);
    step(1, 0, 2, 32'h67, 1, 0, 32'h63, 32'h64, 32'h67, 3'b100, 1);
    @(negedge clk); #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
